// File: rtl/stack_pkg.sv
// Shared constants and the operation encoding for the parametrised LIFO stack.
package stack_pkg;

    localparam int unsigned STACK_DATA_W = 32;
    localparam int unsigned STACK_DEPTH  = 64;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP,
        OP_REPLACE,
        OP_FLUSH
    } stack_op_e;

endpackage

// File: rtl/param_stack_if.sv
// Control, data and status bundle between the CPU datapath and the stack.
interface param_stack_if
    import stack_pkg::*;
#(
    parameter int unsigned DATA_W = STACK_DATA_W,
    parameter int unsigned SP_W   = $clog2(STACK_DEPTH + 1)
);
    logic              enable;
    logic              push;
    logic              pop;
    logic              flush;
    logic              clr_err;
    logic [DATA_W-1:0] data_in;
    logic [SP_W-1:0]   peek_idx;
    logic [DATA_W-1:0] data_out;
    logic [DATA_W-1:0] peek_data;
    logic              peek_valid;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic              overflow;
    logic              underflow;
    logic [SP_W-1:0]   stack_pointer;

    modport master (
        output enable, push, pop, flush, clr_err, data_in, peek_idx,
        input  data_out, peek_data, peek_valid, empty, full, almost_full,
               overflow, underflow, stack_pointer
    );

    modport slave (
        input  enable, push, pop, flush, clr_err, data_in, peek_idx,
        output data_out, peek_data, peek_valid, empty, full, almost_full,
               overflow, underflow, stack_pointer
    );
endinterface

// File: rtl/stack_ram.sv
// DEPTH x DATA_W storage: one synchronous write port, two asynchronous read ports.
module stack_ram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     top_addr,
    output logic [DATA_W-1:0] top_data,
    input  logic [AW-1:0]     peek_addr,
    output logic [DATA_W-1:0] peek_data
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Non-power-of-two depths leave unused address codes; read those as zero.
    always_comb begin
        top_data  = '0;
        peek_data = '0;
        if (32'(top_addr) < DEPTH) begin
            top_data = mem[top_addr];
        end
        if (32'(peek_addr) < DEPTH) begin
            peek_data = mem[peek_addr];
        end
    end
endmodule

// File: rtl/param_stack.sv
// Parametrised LIFO stack: op decode, stack pointer, sticky error flags, output gating.
module param_stack
    import stack_pkg::*;
#(
    parameter int unsigned DATA_W   = STACK_DATA_W,
    parameter int unsigned DEPTH    = STACK_DEPTH,
    parameter int unsigned SP_W     = $clog2(DEPTH + 1),
    parameter int unsigned AF_LEVEL = DEPTH - 2
) (
    input logic         clk,
    input logic         rst,
    param_stack_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    stack_op_e         op;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              is_empty, is_full;
    logic [SP_W-1:0]   sp_m1, peek_off;
    logic              we;
    logic [AW-1:0]     waddr;
    logic [DATA_W-1:0] top_raw, peek_raw;

    assign is_empty = (sp_q == '0);
    assign is_full  = (sp_q == SP_W'(DEPTH));
    assign sp_m1    = sp_q - SP_W'(1);
    assign peek_off = sp_m1 - bus.peek_idx;

    // Push+pop on an empty stack degrades to a plain push.
    always_comb begin
        op = OP_NONE;
        if (bus.enable) begin
            if (bus.flush) begin
                op = OP_FLUSH;
            end else if (bus.push && bus.pop && !is_empty) begin
                op = OP_REPLACE;
            end else if (bus.push) begin
                op = OP_PUSH;
            end else if (bus.pop) begin
                op = OP_POP;
            end
        end
    end

    // A new error event in the same cycle as clr_err keeps the flag set.
    always_comb begin
        sp_d  = sp_q;
        we    = 1'b0;
        waddr = AW'(sp_q);
        ovf_d = ovf_q & ~bus.clr_err;
        unf_d = unf_q & ~bus.clr_err;
        unique case (op)
            OP_PUSH: begin
                if (is_full) begin
                    ovf_d = 1'b1;
                end else begin
                    we   = 1'b1;
                    sp_d = sp_q + SP_W'(1);
                end
            end
            OP_POP: begin
                if (is_empty) begin
                    unf_d = 1'b1;
                end else begin
                    sp_d = sp_m1;
                end
            end
            OP_REPLACE: begin
                we    = 1'b1;
                waddr = AW'(sp_m1);
            end
            OP_FLUSH: sp_d = '0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    stack_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk       (clk),
        .we        (we),
        .waddr     (waddr),
        .wdata     (bus.data_in),
        .top_addr  (AW'(sp_m1)),
        .top_data  (top_raw),
        .peek_addr (AW'(peek_off)),
        .peek_data (peek_raw)
    );

    always_comb begin
        bus.peek_valid    = (bus.peek_idx < sp_q);
        bus.data_out      = is_empty ? '0 : top_raw;
        bus.peek_data     = bus.peek_valid ? peek_raw : '0;
        bus.empty         = is_empty;
        bus.full          = is_full;
        bus.almost_full   = (32'(sp_q) >= AF_LEVEL);
        bus.overflow      = ovf_q;
        bus.underflow     = unf_q;
        bus.stack_pointer = sp_q;
    end
endmodule

// File: tb/tb_param_stack.sv
// Scoreboard bench for param_stack (DEPTH=4, DATA_W=8): stimulus queues expectations, monitor checks.
module tb_param_stack;
    localparam int unsigned DW  = 8;
    localparam int unsigned DEP = 4;
    localparam int unsigned SPW = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    param_stack_if #(.DATA_W(DW), .SP_W(SPW)) bus ();

    param_stack #(
        .DATA_W   (DW),
        .DEPTH    (DEP),
        .SP_W     (SPW),
        .AF_LEVEL (DEP - 2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string           nm;
        logic [SPW-1:0]  sp;
        logic [DW-1:0]   dout;
        logic [DW-1:0]   pdat;
        logic            pv;
        logic            af;
        logic            ovf;
        logic            unf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Packed view: sp, data_out, peek_data, peek_valid, empty, full, almost_full, ovf, unf.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [25:0] got, want;
            e    = exp_q.pop_front();
            want = {e.sp, e.dout, e.pdat, e.pv, (e.sp == 3'd0), (e.sp == 3'(DEP)),
                    e.af, e.ovf, e.unf};
            got  = {bus.stack_pointer, bus.data_out, bus.peek_data, bus.peek_valid,
                    bus.empty, bus.full, bus.almost_full, bus.overflow, bus.underflow};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s: got sp=%0d dout=%h pdat=%h pv=%b e=%b f=%b af=%b ovf=%b unf=%b (packed %h) expected packed %h",
                         e.nm, bus.stack_pointer, bus.data_out, bus.peek_data,
                         bus.peek_valid, bus.empty, bus.full, bus.almost_full,
                         bus.overflow, bus.underflow, got, want);
            end
        end
    end

    // ctl = {rst, enable, flush, push, pop, clr_err}
    task automatic step(input logic [5:0] ctl, input logic [DW-1:0] d,
                        input logic [SPW-1:0] pidx, input string nm,
                        input logic [SPW-1:0] esp, input logic [DW-1:0] edo,
                        input logic [DW-1:0] epd, input logic epv, input logic eaf,
                        input logic eovf, input logic eunf);
        exp_t e;
        {rst, bus.enable, bus.flush, bus.push, bus.pop, bus.clr_err} = ctl;
        bus.data_in = d;
        @(posedge clk);
        #1;
        {rst, bus.enable, bus.flush, bus.push, bus.pop, bus.clr_err} = 6'b010000;
        bus.peek_idx = pidx;
        e.nm = nm; e.sp = esp; e.dout = edo; e.pdat = epd; e.pv = epv;
        e.af = eaf; e.ovf = eovf; e.unf = eunf;
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    localparam logic [5:0] RST = 6'b110000;
    localparam logic [5:0] NOP = 6'b010000;
    localparam logic [5:0] FL  = 6'b011000;
    localparam logic [5:0] PU  = 6'b010100;
    localparam logic [5:0] PO  = 6'b010010;
    localparam logic [5:0] RP  = 6'b010110;
    localparam logic [5:0] CE  = 6'b010001;
    localparam logic [5:0] POC = 6'b010011;
    localparam logic [5:0] FLP = 6'b011100;
    localparam logic [5:0] RPU = 6'b110100;
    localparam logic [5:0] DPU = 6'b000100;
    localparam logic [5:0] DPO = 6'b000010;

    initial begin
        {bus.enable, bus.flush, bus.push, bus.pop, bus.clr_err} = '0;
        bus.data_in  = '0;
        bus.peek_idx = '0;
        @(negedge clk);
        //     ctl  din     pidx  name              sp  dout   pdat   pv  af  ovf unf
        step(RST, 8'h00, 3'd0, "reset",           3'd0, 8'h00, 8'h00, 0, 0, 0, 0);
        step(PU,  8'h0A, 3'd0, "push_a",          3'd1, 8'h0A, 8'h0A, 1, 0, 0, 0);
        step(PU,  8'h0B, 3'd0, "push_b",          3'd2, 8'h0B, 8'h0B, 1, 1, 0, 0);
        step(PU,  8'h0C, 3'd2, "push_c_peek2",    3'd3, 8'h0C, 8'h0A, 1, 1, 0, 0);
        step(NOP, 8'h00, 3'd3, "peek3_invalid",   3'd3, 8'h0C, 8'h00, 0, 1, 0, 0);
        step(PU,  8'h0D, 3'd1, "push_d_full",     3'd4, 8'h0D, 8'h0C, 1, 1, 0, 0);
        step(PU,  8'h0E, 3'd0, "push_e_overflow", 3'd4, 8'h0D, 8'h0D, 1, 1, 1, 0);
        step(CE,  8'h00, 3'd0, "clr_overflow",    3'd4, 8'h0D, 8'h0D, 1, 1, 0, 0);
        step(RP,  8'h09, 3'd1, "replace_full",    3'd4, 8'h09, 8'h0C, 1, 1, 0, 0);
        step(FL,  8'h00, 3'd0, "flush_full",      3'd0, 8'h00, 8'h00, 0, 0, 0, 0);
        step(PO,  8'h00, 3'd0, "pop_empty",       3'd0, 8'h00, 8'h00, 0, 0, 0, 1);
        step(POC, 8'h00, 3'd0, "clr_and_pop",     3'd0, 8'h00, 8'h00, 0, 0, 0, 1);
        step(CE,  8'h00, 3'd0, "clr_underflow",   3'd0, 8'h00, 8'h00, 0, 0, 0, 0);
        step(PU,  8'h03, 3'd0, "push_3",          3'd1, 8'h03, 8'h03, 1, 0, 0, 0);
        step(PU,  8'h05, 3'd1, "push_5",          3'd2, 8'h05, 8'h03, 1, 1, 0, 0);
        step(RP,  8'h09, 3'd1, "replace_sp2",     3'd2, 8'h09, 8'h03, 1, 1, 0, 0);
        step(PO,  8'h00, 3'd0, "pop_to_1",        3'd1, 8'h03, 8'h03, 1, 0, 0, 0);
        step(PO,  8'h00, 3'd0, "pop_to_0",        3'd0, 8'h00, 8'h00, 0, 0, 0, 0);
        step(RP,  8'h06, 3'd0, "replace_empty",   3'd1, 8'h06, 8'h06, 1, 0, 0, 0);
        step(PU,  8'h01, 3'd0, "push_1",          3'd2, 8'h01, 8'h01, 1, 1, 0, 0);
        step(PU,  8'h02, 3'd2, "push_2",          3'd3, 8'h02, 8'h06, 1, 1, 0, 0);
        step(FLP, 8'h0F, 3'd0, "flush_with_push", 3'd0, 8'h00, 8'h00, 0, 0, 0, 0);
        step(PU,  8'h07, 3'd0, "push_7",          3'd1, 8'h07, 8'h07, 1, 0, 0, 0);
        step(PO,  8'h00, 3'd0, "pop_7",           3'd0, 8'h00, 8'h00, 0, 0, 0, 0);
        step(PO,  8'h00, 3'd0, "set_underflow",   3'd0, 8'h00, 8'h00, 0, 0, 0, 1);
        step(PU,  8'h01, 3'd0, "push_1b",         3'd1, 8'h01, 8'h01, 1, 0, 0, 1);
        step(RPU, 8'h44, 3'd0, "rst_with_push",   3'd0, 8'h00, 8'h00, 0, 0, 0, 0);
        step(DPU, 8'h55, 3'd0, "disabled_push",   3'd0, 8'h00, 8'h00, 0, 0, 0, 0);
        step(DPO, 8'h00, 3'd0, "disabled_pop",    3'd0, 8'h00, 8'h00, 0, 0, 0, 0);
        step(PU,  8'h11, 3'd0, "push_11",         3'd1, 8'h11, 8'h11, 1, 0, 0, 0);
        step(DPU, 8'h22, 3'd0, "disabled_hold",   3'd1, 8'h11, 8'h11, 1, 0, 0, 0);

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/param_stack.md
Name: param_stack

Overview:
- Parametrised LIFO stack. Next generation of the processor's stack-pointer/stack-memory block.
- Used by the CPU datapath for call/return and PUSH/POP instructions.
- Generalises data width and depth. Adds full detection, sticky overflow/underflow error flags, same-cycle push+pop (replace top), flush, and an indexed peek port for stack-relative reads.

Parameters:
- DATA_W, 32, width of each stack entry in bits.
- DEPTH, 64, number of entries; any value >= 2, not required to be a power of two.
- SP_W, $clog2(DEPTH+1), stack-pointer width; must be able to hold the value DEPTH.
- AF_LEVEL, DEPTH-2, occupancy at or above which almost_full is asserted.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  qualifies push, pop and flush; when low, no state changes.
- push  in  1  push data_in onto the stack.
- pop  in  1  remove the top entry.
- flush  in  1  empty the stack in one cycle.
- clr_err  in  1  clear the sticky error flags.
- data_in  in  DATA_W  value to push.
- peek_idx  in  SP_W  offset from the top; 0 selects the top entry.
- data_out  out  DATA_W  top-of-stack value (combinational).
- peek_data  out  DATA_W  entry at offset peek_idx below the top (combinational).
- peek_valid  out  1  peek_idx < sp.
- empty  out  1  sp == 0.
- full  out  1  sp == DEPTH.
- almost_full  out  1  sp >= AF_LEVEL.
- overflow  out  1  sticky flag: a push was attempted while full.
- underflow  out  1  sticky flag: a pop was attempted while empty.
- stack_pointer  out  SP_W  current occupancy, zero-extended.

Behaviour:
- Reset (rst high at a clk edge):
  - sp=0, overflow=0, underflow=0.
  - Storage contents are not cleared.
  - Outputs after reset: data_out=0, peek_data=0, peek_valid=0, empty=1, full=0, almost_full=(AF_LEVEL==0), stack_pointer=0.
  - rst has priority over every other input.
- enable low: sp, storage and error flags hold. clr_err still acts.
- Operation priority when enable is high: flush > (push and pop) > push > pop.
- flush:
  - sp <= 0 next cycle; storage untouched.
  - Push and pop in the same cycle are ignored and never raise errors.
- push only:
  - Not full: mem[sp] <= data_in, sp <= sp+1.
  - Full: no write, sp holds, overflow <= 1.
- pop only:
  - Not empty: sp <= sp-1.
  - Empty: sp holds, underflow <= 1.
- push and pop together:
  - Not empty: replace top, i.e. mem[sp-1] <= data_in, sp unchanged. No error even when full.
  - Empty: treated as push only (mem[0] <= data_in, sp <= 1). No underflow.
- Read-side latency:
  - Writes and sp changes are visible on data_out and peek_data the cycle after the edge.
  - There is no write-through bypass.
- data_out = empty ? 0 : mem[sp-1].
- peek_data = peek_valid ? mem[sp-1-peek_idx] : 0. Index arithmetic is SP_W bits wide, with no wrap-around; out-of-range indices are gated by peek_valid.
- Error flags:
  - clr_err clears both flags.
  - If clr_err and a new error event occur in the same cycle, the new event wins and the flag stays at 1.
- The stack pointer never wraps. It saturates at 0 and at DEPTH.

Decomposition:
- Package stack_pkg holds:
  - default DATA_W and DEPTH constants;
  - an operation-select enum (OP_NONE, OP_PUSH, OP_POP, OP_REPLACE, OP_FLUSH) decoded from the control inputs.
- One sub-module, stack_ram:
  - DEPTH x DATA_W storage;
  - one synchronous write port;
  - two asynchronous read ports (top and peek).
- param_stack contains the op decoder, sp register, flags and output gating.

Test Plan:
- Reset, then push 0xA, 0xB, 0xC on consecutive cycles (DEPTH=4) -> stack_pointer=3, data_out=0xC, peek_idx=2 gives peek_data=0xA with peek_valid=1, and peek_idx=3 gives peek_valid=0 and peek_data=0.
- Push a 4th value 0xD, then push 0xE -> full=1, sp=4, data_out=0xD, overflow=1. Assert clr_err -> overflow=0.
- From empty, pop -> underflow=1, sp=0, data_out=0. Next cycle, clr_err and pop together -> underflow stays 1.
- With sp=2 and top 0x5, assert push+pop with data_in 0x9 -> sp=2, data_out=0x9, no flags. Repeat while full -> no overflow.
- Fill to 3 entries, assert flush together with push -> sp=0, empty=1, no error. Push 0x7 -> data_out=0x7.
- Push 0x1, then in the next cycle assert rst and push together -> sp=0, empty=1, flags 0. With enable=0, push -> no change.
